// File: rtl/axi_dmem_line_master.sv
// AXI4 line master: one D-cache line refill (AR/R) or writeback (AW/W/B)
// per request as a single INCR burst, one transaction in flight.
module axi_dmem_line_master #(
  parameter int ADDR_W     = 49,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 6,
  parameter int LINE_BYTES = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [LINE_BYTES*8-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic [ID_W-1:0]         AWID,
  output logic [ADDR_W-1:0]       AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWLOCK,
  output logic [3:0]              AWCACHE,
  output logic [2:0]              AWPROT,
  output logic [3:0]              AWQOS,
  output logic                    AWUSER,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_W-1:0]       WDATA,
  output logic [DATA_W/8-1:0]     WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_W-1:0]         BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ID_W-1:0]         ARID,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARLOCK,
  output logic [3:0]              ARCACHE,
  output logic [2:0]              ARPROT,
  output logic [3:0]              ARQOS,
  output logic                    ARUSER,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_W-1:0]         RID,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BEATS  = LINE_BYTES / STRB_W;
  localparam int LINE_W = LINE_BYTES * 8;

  localparam logic [7:0]        LAST_CNT = 8'(BEATS - 1);
  localparam logic [2:0]        SIZE     = 3'($clog2(STRB_W));
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);
  localparam logic [ID_W-1:0]   ID       = ID_W'(AXI_ID);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic              rsp_valid_q;

  logic cnt_last, r_hs, w_hs, b_hs, r_end, r_bad;
  logic unused_resp;

  assign cnt_last = (cnt_q == LAST_CNT);
  assign r_hs     = RVALID & RREADY;
  assign w_hs     = WVALID & WREADY;
  assign b_hs     = BVALID & BREADY;
  assign r_end    = cnt_last | RLAST;
  assign r_bad    = RRESP[1] | (RID != ID) | (RLAST != cnt_last);
  assign unused_resp = ^{RRESP[0], BRESP[0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_we ? S_AW : S_AR;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = S_R;
      end
      S_R: begin
        RREADY = 1'b1;
        if (RVALID && r_end) state_d = S_IDLE;
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = S_W;
      end
      S_W: begin
        WVALID = 1'b1;
        if (WREADY && cnt_last) state_d = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (req_valid && req_ready) begin
        addr_q  <= req_addr & ~OFF_MASK;
        wdata_q <= req_wdata;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (r_hs) begin
        rdata_q[cnt_q*DATA_W +: DATA_W] <= RDATA;
        cnt_q <= cnt_q + 8'd1;
        if (r_bad) err_q <= 1'b1;
        if (r_end) rsp_valid_q <= 1'b1;
      end
      if (w_hs) cnt_q <= cnt_q + 8'd1;
      if (b_hs) begin
        if (BRESP[1] || BID != ID) err_q <= 1'b1;
        rsp_valid_q <= 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign AWID    = ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = LAST_CNT;
  assign AWSIZE  = SIZE;
  assign AWBURST = 2'b01;
  assign AWLOCK  = 1'b0;
  assign AWCACHE = 4'b0011;
  assign AWPROT  = 3'b000;
  assign AWQOS   = 4'b0000;
  assign AWUSER  = 1'b0;

  assign ARID    = ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = LAST_CNT;
  assign ARSIZE  = SIZE;
  assign ARBURST = 2'b01;
  assign ARLOCK  = 1'b0;
  assign ARCACHE = 4'b0011;
  assign ARPROT  = 3'b000;
  assign ARQOS   = 4'b0000;
  assign ARUSER  = 1'b0;

  assign WDATA = wdata_q[cnt_q*DATA_W +: DATA_W];
  assign WSTRB = '1;
  assign WLAST = cnt_last;

endmodule

// File: tb/tb_axi_dmem_line_master.sv
// Directed bench for axi_dmem_line_master: vector table of line
// transactions plus hand sequences for back-pressure and mid-burst reset.
module tb_axi_dmem_line_master;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         req_valid, req_ready, req_we;
  logic [48:0]  req_addr;
  logic [511:0] req_wdata;
  logic         rsp_valid, rsp_err;
  logic [511:0] rsp_rdata;
  logic [5:0]   AWID, ARID, BID, RID;
  logic [48:0]  AWADDR, ARADDR;
  logic [7:0]   AWLEN, ARLEN;
  logic [2:0]   AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]   AWBURST, ARBURST, BRESP, RRESP;
  logic         AWLOCK, ARLOCK, AWUSER, ARUSER;
  logic [3:0]   AWCACHE, ARCACHE, AWQOS, ARQOS;
  logic         AWVALID, AWREADY, ARVALID, ARREADY;
  logic [63:0]  WDATA, RDATA;
  logic [7:0]   WSTRB;
  logic         WLAST, WVALID, WREADY;
  logic         BVALID, BREADY;
  logic         RLAST, RVALID, RREADY;

  axi_dmem_line_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE),
    .AWPROT(AWPROT), .AWQOS(AWQOS), .AWUSER(AWUSER),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
    .ARPROT(ARPROT), .ARQOS(ARQOS), .ARUSER(ARUSER),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          we;
    logic [48:0] addr;
    logic [48:0] exp_addr;
    int          seed;
    int          err_beat;
    int          badid_beat;
    int          rlast_beat;
    logic [1:0]  bresp;
    logic [5:0]  bid;
    bit          wtoggle;
    int          ar_delay;
    bit          exp_err;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  logic [511:0] exp_line;
  logic [511:0] wline;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] pat(int seed, int k);
    return {16'hC0DE, 16'(seed), 24'h5A5A5A, 8'(k)};
  endfunction

  task automatic do_req(vec_t v);
    int n = 0;
    for (int k = 0; k < 8; k++) wline[k*64 +: 64] = pat(v.seed, k);
    req_we = v.we;
    req_addr = v.addr;
    req_wdata = wline;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("req_ready_wait", 512'(req_ready), 512'd1);
    @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  task automatic serve_read(vec_t v);
    int n = 0;
    int nb;
    while (!ARVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("arvalid", 512'(ARVALID), 512'd1);
    for (int d = 0; d < v.ar_delay; d++) begin
      ARREADY = 1'b0;
      chk("ar_hold_valid", 512'(ARVALID), 512'd1);
      chk("ar_hold_addr", 512'(ARADDR), 512'(v.exp_addr));
      chk("ar_hold_len", 512'(ARLEN), 512'd7);
      chk("ar_hold_rdy", 512'(req_ready), 512'd0);
      @(negedge ACLK);
    end
    chk("araddr", 512'(ARADDR), 512'(v.exp_addr));
    chk("ar_len_size_burst", 512'({ARLEN, ARSIZE, ARBURST}),
        512'({8'd7, 3'd3, 2'b01}));
    chk("ar_id_cache", 512'({ARID, ARCACHE, ARLOCK, ARPROT, ARQOS, ARUSER}),
        512'({6'd0, 4'b0011, 1'b0, 3'd0, 4'd0, 1'b0}));
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    nb = (v.rlast_beat < 7 ? v.rlast_beat : 7) + 1;
    for (int k = 0; k < nb; k++) begin
      RVALID = 1'b1;
      RDATA  = pat(v.seed, k);
      RLAST  = (k == v.rlast_beat);
      RRESP  = (k == v.err_beat) ? 2'b10 : 2'b00;
      RID    = (k == v.badid_beat) ? 6'd5 : 6'd0;
      chk("rready", 512'(RREADY), 512'd1);
      exp_line[k*64 +: 64] = pat(v.seed, k);
      @(negedge ACLK);
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    RID    = 6'd0;
    chk("r_rsp_valid", 512'(rsp_valid), 512'd1);
    chk("r_rsp_err", 512'(rsp_err), 512'(v.exp_err));
    chk("r_rsp_rdata", rsp_rdata, exp_line);
    chk("r_idle", 512'({req_ready, RREADY}), 512'(2'b10));
    @(negedge ACLK);
    chk("r_one_pulse", 512'(rsp_valid), 512'd0);
  endtask

  task automatic serve_write(vec_t v);
    int n = 0;
    int k = 0;
    int cyc = 0;
    while (!AWVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("awvalid", 512'(AWVALID), 512'd1);
    chk("awaddr", 512'(AWADDR), 512'(v.exp_addr));
    chk("aw_len_size_burst", 512'({AWLEN, AWSIZE, AWBURST, AWCACHE}),
        512'({8'd7, 3'd3, 2'b01, 4'b0011}));
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0;
    while (k < 8 && cyc < 40) begin
      WREADY = v.wtoggle ? cyc[0] : 1'b1;
      chk("wvalid", 512'(WVALID), 512'd1);
      chk("wdata", 512'(WDATA), 512'(pat(v.seed, k)));
      if (WREADY) begin
        chk("wstrb_wlast", 512'({WSTRB, WLAST}), 512'({8'hFF, k == 7}));
        k++;
      end
      @(negedge ACLK);
      cyc++;
    end
    WREADY = 1'b0;
    chk("w_beats", 512'(k), 512'd8);
    chk("bready", 512'({BREADY, WVALID}), 512'(2'b10));
    BVALID = 1'b1;
    BRESP  = v.bresp;
    BID    = v.bid;
    @(negedge ACLK);
    BVALID = 1'b0;
    BRESP  = 2'b00;
    BID    = 6'd0;
    chk("b_rsp_valid", 512'(rsp_valid), 512'd1);
    chk("b_rsp_err", 512'(rsp_err), 512'(v.exp_err));
    @(negedge ACLK);
    chk("b_one_pulse", 512'(rsp_valid), 512'd0);
  endtask

  task automatic run_vec(vec_t v);
    do_req(v);
    if (v.we) serve_write(v);
    else      serve_read(v);
  endtask

  vec_t tbl[9];
  vec_t hv, hv2;

  initial begin
    tbl[0] = '{0, 49'h1000_0047, 49'h1000_0040, 1, -1, -1, 7, 2'b00, 6'd0, 0, 0, 0};
    tbl[1] = '{1, 49'h2000_0013, 49'h2000_0000, 2, -1, -1, 7, 2'b00, 6'd0, 1, 0, 0};
    tbl[2] = '{0, 49'h3000_00FF, 49'h3000_00C0, 3, 3, -1, 7, 2'b00, 6'd0, 0, 0, 1};
    tbl[3] = '{0, 49'h0000_0040, 49'h0000_0040, 4, -1, -1, 5, 2'b00, 6'd0, 0, 0, 1};
    tbl[4] = '{1, 49'h123_4567_89AB, 49'h123_4567_8980, 5, -1, -1, 7, 2'b10, 6'd0, 0, 0, 1};
    tbl[5] = '{0, 49'h0000_007F, 49'h0000_0040, 6, -1, -1, 8, 2'b00, 6'd0, 0, 0, 1};
    tbl[6] = '{1, 49'h0ABC_0FC1, 49'h0ABC_0FC0, 7, -1, -1, 7, 2'b01, 6'd0, 1, 0, 0};
    tbl[7] = '{0, 49'h0000_1234, 49'h0000_1200, 8, -1, 2, 7, 2'b00, 6'd0, 0, 0, 1};
    tbl[8] = '{1, 49'h0000_2000, 49'h0000_2000, 9, -1, -1, 7, 2'b00, 6'd3, 0, 0, 1};

    ARESET = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    BID = '0; BRESP = '0; BVALID = 0;
    RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
    exp_line = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_valids", 512'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 512'd0);
    chk("rst_rsp", 512'({rsp_valid, rsp_err}), 512'd0);
    chk("rst_rdata", rsp_rdata, 512'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_req_ready", 512'(req_ready), 512'd1);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // long ARREADY stall with a second request already waiting
    hv  = '{0, 49'h5000_0008, 49'h5000_0000, 10, -1, -1, 7, 2'b00, 6'd0, 0, 20, 0};
    hv2 = '{0, 49'h6000_0081, 49'h6000_0080, 11, -1, -1, 7, 2'b00, 6'd0, 0, 0, 0};
    do_req(hv);
    req_we = 1'b0;
    req_addr = hv2.addr;
    req_valid = 1'b1;
    serve_read(hv);
    req_valid = 1'b0;
    chk("b2b_accept", 512'(ARVALID), 512'd1);
    chk("b2b_addr", 512'(ARADDR), 512'(hv2.exp_addr));
    serve_read(hv2);

    // reset while write beat 4 is on the bus
    hv = '{1, 49'h7000_0000, 49'h7000_0000, 12, -1, -1, 7, 2'b00, 6'd0, 0, 0, 0};
    do_req(hv);
    chk("rst6_awvalid", 512'(AWVALID), 512'd1);
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0;
    WREADY = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("rst6_beat4", 512'({WVALID, WDATA}), 512'({1'b1, pat(12, 4)}));
    ARESET = 1'b1;
    #1;
    chk("rst6_valids", 512'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 512'd0);
    chk("rst6_rsp", 512'(rsp_valid), 512'd0);
    WREADY = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst6_req_ready", 512'({req_ready, rsp_valid}), 512'(2'b10));
    chk("rst6_rdata", rsp_rdata, 512'd0);
    exp_line = '0;
    hv = '{0, 49'h7100_0044, 49'h7100_0040, 13, -1, -1, 7, 2'b00, 6'd0, 0, 0, 0};
    run_vec(hv);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
